dm_access_ctrl: RTL and testbench

- Initiator-side controller that drives the 4 KB word-addressed data memory on behalf of the datapath.
- Accepts byte, halfword and word loads and stores through a valid/ready request channel.
- Performs read-modify-write for sub-word stores, and sign- or zero-extends loads.
- Flags misaligned or out-of-window accesses, and returns one response per request through a valid/ready response channel.

---
 rtl/dm_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: sized loads/stores over valid/ready,
// sub-word read-modify-write, load extension and access error flagging.
module dm_access_ctrl #(
  parameter logic [31:0] DM_BASE     = 32'h0000_0000,
  parameter bit          RANGE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_wen,
  input  logic [31:0] dm_dout
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, MERGE, RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_err;
  logic        w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  logic [31:0] w_mrg;

  always_comb begin
    w_err = 1'b0;
    unique case (1'b1)
      (req_size == 2'b11):                       w_err = 1'b1;
      (req_size == 2'b01 && req_addr[0]):        w_err = 1'b1;
      (req_size == 2'b10 && req_addr[1:0] != 2'b00):
                                                 w_err = 1'b1;
      (RANGE_CHECK &&
       req_addr[31:12] != DM_BASE[31:12]):       w_err = 1'b1;
      default:                                   w_err = 1'b0;
    endcase
  end

  assign w_word = (r_size == 2'b10);

  always_comb begin
    w_byte = dm_dout[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = dm_dout[7:0];
      2'd1: w_byte = dm_dout[15:8];
      2'd2: w_byte = dm_dout[23:16];
      2'd3: w_byte = dm_dout[31:24];
      default: w_byte = dm_dout[7:0];
    endcase
    w_half = r_addr[1] ? dm_dout[31:16] : dm_dout[15:0];
    w_ld = dm_dout;
    if (r_size == 2'b00)
      w_ld = {{24{~r_uns & w_byte[7]}}, w_byte};
    else if (r_size == 2'b01)
      w_ld = {{16{~r_uns & w_half[15]}}, w_half};
  end

  // Replace only the addressed lane(s) of the word read in ACCESS
  always_comb begin
    w_mrg = r_merge;
    if (r_size == 2'b00) begin
      case (r_addr[1:0])
        2'd0: w_mrg[7:0]   = r_wdata[7:0];
        2'd1: w_mrg[15:8]  = r_wdata[7:0];
        2'd2: w_mrg[23:16] = r_wdata[7:0];
        2'd3: w_mrg[31:24] = r_wdata[7:0];
        default: w_mrg = r_merge;
      endcase
    end else if (r_addr[1]) begin
      w_mrg[31:16] = r_wdata[15:0];
    end else begin
      w_mrg[15:0] = r_wdata[15:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    dm_wen      = 1'b0;
    dm_din      = 32'h0;
    unique case (r_state)
      IDLE: begin
        if (req_valid)
          w_state_nxt = w_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (r_we && !w_word) begin
          w_state_nxt = MERGE;
        end else begin
          w_state_nxt = RESP;
          dm_wen      = r_we;
          dm_din      = r_we ? r_wdata : 32'h0;
        end
      end
      MERGE: begin
        w_state_nxt = RESP;
        dm_wen      = 1'b1;
        dm_din      = w_mrg;
      end
      RESP: begin
        if (resp_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= 12'h0;
      r_wdata <= 32'h0;
      r_merge <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr[11:0];
            r_wdata <= req_wdata;
            r_err   <= w_err;
            r_rdata <= 32'h0;
          end
        end
        ACCESS: begin
          if (!r_we)
            r_rdata <= w_ld;
          else if (!w_word)
            r_merge <= dm_dout;
        end
        RESP: begin
          if (resp_ready) begin
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign dm_addr    = r_addr[11:2];

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural
// 1K-word data memory and hand-computed expectations.
module tb_dm_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_wen;
  logic [31:0] dm_dout;

  logic [31:0] mem [1024];
  logic        pre_en;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  int          wen_cnt;
  logic [9:0]  wen_addr;
  int          n_tests;
  int          n_fail;

  dm_access_ctrl #(
    .DM_BASE(32'h0000_0000),
    .RANGE_CHECK(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .dm_addr(dm_addr),
    .dm_din(dm_din),
    .dm_wen(dm_wen),
    .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  initial begin
    wen_cnt  = 0;
    wen_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (dm_wen) begin
      mem[dm_addr] <= dm_din;
      wen_cnt  = wen_cnt + 1;
      wen_addr = dm_addr;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  // Issue one request from IDLE; returns cycles to resp_valid
  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, output int lat);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic xact(input string tag, input logic we,
                      input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_wen);
    int lat;
    int w0;
    w0 = wen_cnt;
    issue(we, sz, uns, a, wd, lat);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".rdata"}, resp_rdata, exp_rd);
    check({tag, ".err"}, {31'h0, resp_err}, {31'h0, exp_err});
    check({tag, ".rdy"}, {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check({tag, ".wen"}, wen_cnt - w0, exp_wen);
    check({tag, ".done"}, {30'h0, resp_valid, resp_err}, 32'h0);
  endtask

  initial begin
    int lat;
    int w0;
    logic [31:0] held;
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b1;
    pre_en       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.rdy", {31'h0, req_ready}, 32'h1);
    check("rst.vld", {31'h0, resp_valid}, 32'h0);
    check("rst.wen", {31'h0, dm_wen}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    xact("st_w", 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF,
         2, 32'h0, 1'b0, 1);
    check("st_w.addr", {22'h0, wen_addr}, 32'd4);
    check("st_w.mem", mem[4], 32'hDEADBEEF);
    xact("ld_w", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0,
         2, 32'hDEADBEEF, 1'b0, 0);

    poke(10'd4, 32'h11223344);
    xact("st_b", 1'b1, 2'b00, 1'b0, 32'h013, 32'hFFFFFFAA,
         3, 32'h0, 1'b0, 1);
    check("st_b.mem", mem[4], 32'hAA223344);
    xact("st_h", 1'b1, 2'b01, 1'b0, 32'h010, 32'hFFFF5566,
         3, 32'h0, 1'b0, 1);
    check("st_h.mem", mem[4], 32'hAA225566);

    poke(10'd4, 32'h80F07F01);
    xact("lb_s", 1'b0, 2'b00, 1'b0, 32'h012, 32'h0,
         2, 32'hFFFFFFF0, 1'b0, 0);
    xact("lb_u", 1'b0, 2'b00, 1'b1, 32'h012, 32'h0,
         2, 32'h000000F0, 1'b0, 0);
    xact("lh_s", 1'b0, 2'b01, 1'b0, 32'h012, 32'h0,
         2, 32'hFFFF80F0, 1'b0, 0);
    xact("lb_0", 1'b0, 2'b00, 1'b0, 32'h010, 32'h0,
         2, 32'h00000001, 1'b0, 0);
    xact("lh_u", 1'b0, 2'b01, 1'b1, 32'h012, 32'h0,
         2, 32'h000080F0, 1'b0, 0);

    xact("e_wal", 1'b1, 2'b10, 1'b0, 32'h012, 32'h12345678,
         1, 32'h0, 1'b1, 0);
    xact("e_hal", 1'b1, 2'b01, 1'b0, 32'h011, 32'h12345678,
         1, 32'h0, 1'b1, 0);
    xact("e_sz", 1'b1, 2'b11, 1'b0, 32'h010, 32'h12345678,
         1, 32'h0, 1'b1, 0);
    xact("e_rng", 1'b1, 2'b10, 1'b0, 32'h1010, 32'h12345678,
         1, 32'h0, 1'b1, 0);
    check("e.mem", mem[4], 32'h80F07F01);

    resp_ready = 1'b0;
    w0 = wen_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, lat);
    check("bp.lat", lat, 2);
    held = 32'h80F07F01;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h020;
    req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp.vld", {31'h0, resp_valid}, 32'h1);
      check("bp.rdata", resp_rdata, held);
      check("bp.rdy", {31'h0, req_ready}, 32'h0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.rel", {31'h0, resp_valid}, 32'h0);
    check("bp.wen", wen_cnt - w0, 0);
    check("bp.mem8", mem[8], 32'h0);

    w0 = wen_cnt;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h011;
    req_wdata    = 32'h000000AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rm.wen_merge", {31'h0, dm_wen}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rm.wen", {31'h0, dm_wen}, 32'h0);
    check("rm.rdy", {31'h0, req_ready}, 32'h1);
    check("rm.vld", {30'h0, resp_valid, resp_err}, 32'h0);
    check("rm.rdata", resp_rdata, 32'h0);
    check("rm.addr", {22'h0, dm_addr}, 32'h0);
    check("rm.din", dm_din, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rm.mem", mem[4], 32'h80F07F01);
    check("rm.nowr", wen_cnt - w0, 0);
    xact("rm.ld", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0,
         2, 32'h80F07F01, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
